spi_slave_regif: RTL and testbench
==================================

Name: spi_slave_regif

Overview:
SPI Mode-0 responder that accepts 32-bit MAX30003-style frames: a 7-bit address, an R/W bit and 24 data bits, MSB first. It oversamples SCLK, CS and MOSI on the 100 MHz system clock and turns each frame into a register read or write strobe. It is the far end of our SPI master. It lets the ECG front-end controller be exercised against an emulated sensor, and it exposes an internal register bank to an external host.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on SCLK, CS and MOSI.
FRAME_BITS, 32, bits per frame; fixed by the frame format.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
sclk  input  1  SPI clock from the master; asynchronous to clk; idles low
cs  input  1  chip select, active low; asynchronous
mosi  input  1  serial data from the master
miso  output  1  serial data to the master
miso_oe  output  1  MISO drive enable; high only while cs is low
reg_addr  output  7  address field of the frame, held from bit 24 until the next frame
reg_rd_req  output  1  one-cycle pulse requesting a read at reg_addr
reg_rd_data  input  24  read data; must be valid exactly 1 clk after reg_rd_req
reg_wr_en  output  1  one-cycle write strobe
reg_wr_data  output  24  write data; valid while reg_wr_en is high
frame_done  output  1  one-cycle pulse after a complete 32-bit frame ends (CS rises)
frame_err  output  1  one-cycle pulse when CS rises with fewer than 32 bits received
rx_frame  output  32  last complete frame received; updated when frame_done fires

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears everything:
  - all outputs go to 0 and the FSM goes to IDLE;
  - the bit counter and both shift registers clear.
  - Reset mid-frame abandons the frame. There is no write and no frame_err.
  - The next frame is accepted only after CS has been seen high.
- Input sampling:
  - SCLK, CS and MOSI each pass through SYNC_STAGES flip-flops plus one edge-detect register.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge detection lags the pin by SYNC_STAGES+1 clk.
  - Supported timing: SCLK half-period ≥ 8 clk, CS setup to the first SCLK rise ≥ 4 clk. Both are met at 2 MHz SCLK (25 clk per half-period).
- Frame format, bit 31 first:
  - [31:25] address;
  - [24] R/W, where 1 = read and 0 = write;
  - [23:0] data.
- Mode 0 timing:
  - MOSI is sampled on each synchronized SCLK rise.
  - MISO changes only on a synchronized SCLK fall.
- FSM states: IDLE, CMD, DATA, HOLD.
  - IDLE: miso_oe=0, miso=0, bit_cnt=0. On a CS fall, go to CMD and set miso_oe=1.
  - CMD: shift MOSI in on each rise; miso stays 0. On the 8th rise:
    - latch reg_addr from shift[6:0] together with the incoming R/W bit;
    - if R/W=1, pulse reg_rd_req on the next clk and load reg_rd_data into tx_shift 1 clk later (no SCLK fall can occur in that window);
    - go to DATA.
  - DATA: on each fall, miso = tx_shift[23] and shift left. For a write frame, miso is 0.
    - On the 32nd rise (bit_cnt reaches 32), latch rx_frame_next.
    - For a write: pulse reg_wr_en with reg_wr_data = bits [23:0] on the clk after the 32nd rise.
    - Go to HOLD.
  - HOLD: further SCLK edges are ignored; miso=0 and bit_cnt saturates at 32.
    - On a CS rise: rx_frame is updated, frame_done pulses, and the FSM goes to IDLE.
- A CS rise in CMD or DATA:
  - pulses frame_err and returns to IDLE;
  - causes no reg_wr_en and no change to rx_frame;
  - a reg_rd_req already issued stands.
- A CS fall while not in IDLE cannot occur, since CS must rise first. A CS rise and an SCLK rise in the same clk: CS wins and the bit is discarded.
- Back-to-back frames with CS high for ≥ 4 clk are each handled independently.
- reg_rd_req and reg_wr_en never fire in the same frame, and each fires at most once per frame.

Decomposition:
- Package ecg_spi_pkg holds:
  - FRAME_BITS=32, ADDR_W=7, DATA_W=24, CMD_BITS=8;
  - RW_BIT=24, SPI_RD=1'b1;
  - the state typedef/encoding for IDLE, CMD, DATA, HOLD.
- One natural sub-module, spi_sync_edge: a SYNC_STAGES synchronizer plus rise/fall detector. Instantiate it three times, for sclk, cs and mosi.

Test Plan:
- Write frame 0x12_3456_78 = addr 0x09, W, data 0x345678, at 2 MHz SCLK → one reg_wr_en with reg_addr=0x09 and reg_wr_data=0x345678; on CS rise frame_done=1 and rx_frame=0x12345678; no reg_rd_req.
- Read frame with addr 0x0F and R (first byte 0x1F), bench returns reg_rd_data=0xA5C3F0 → one reg_rd_req with reg_addr=0x0F; MISO bits 23..0 read by the master = 0xA5C3F0; MISO=0 during the first 8 bits; no reg_wr_en.
- Abort: CS rises after 20 bits of a write to addr 0x01 → frame_err pulses once; no reg_wr_en, no frame_done; rx_frame unchanged.
- Overrun: 40 SCLK cycles in one CS window (write 0x02, data 0x000001) → exactly one reg_wr_en with data 0x000001; frame_done on CS rise; MISO=0 for bits 33-40.
- Reset mid-frame at bit 12, then a clean write to addr 0x03 with data 0xFFFFFF → all outputs are 0 during reset; the first frame produces no strobes; the second produces reg_wr_en with reg_wr_data=0xFFFFFF.
- Back-to-back read then write with CS high for 4 clk between them, at the minimum SCLK half-period of 8 clk → both frames are decoded correctly, with two frame_done pulses and zero frame_err pulses.

Source files
------------

// File: rtl/ecg_spi_pkg.sv
// Shared constants and FSM encoding for the SPI register-interface responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecg_spi_pkg;

   localparam int FRAME_BITS = 32;   // address + R/W + data
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 24;
   localparam int CMD_BITS   = 8;    // address + R/W, the leading byte
   localparam int RW_BIT     = 24;   // frame bit position of R/W
   localparam logic SPI_RD   = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } spi_state_t;

endpackage

// File: rtl/spi_slave_regif_if.sv
// Register-bank side bus of the SPI responder: address, read request/data, write strobe/data.
// Latency: read data is expected exactly 1 clk after reg_rd_req.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
// Ports (members): reg_addr, reg_rd_req, reg_rd_data, reg_wr_en, reg_wr_data.
interface spi_slave_regif_if;
   import ecg_spi_pkg::*;

   logic [ADDR_W-1:0] reg_addr;
   logic              reg_rd_req;
   logic [DATA_W-1:0] reg_rd_data;
   logic              reg_wr_en;
   logic [DATA_W-1:0] reg_wr_data;

   // master: the SPI responder issuing register accesses
   modport master (
      output reg_addr, reg_rd_req, reg_wr_en, reg_wr_data,
      input  reg_rd_data
   );

   // slave: the register bank answering them
   modport slave (
      input  reg_addr, reg_rd_req, reg_wr_en, reg_wr_data,
      output reg_rd_data
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus rise/fall detector.
// Latency: level after SYNC_STAGES clk; rise/fall act SYNC_STAGES+1 clk after the pin.
// Backpressure: none.
// Ports: clk, rst (sync, active high), din (async pin), level, rise, fall.
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI mode-0 responder turning 32-bit addr/RW/data frames into register read/write strobes.
// Latency: pins seen SYNC_STAGES+1 clk late; rd_req 1 clk after 8th SCLK rise, wr_en 1 clk after 32nd.
// Backpressure: none; the register bank must answer reads exactly 1 clk after reg_rd_req.
// Ports: clk, rst, sclk/cs/mosi (async pins), miso/miso_oe, reg_bus (register bank),
//        frame_done/frame_err pulses, rx_frame (last complete frame).
module spi_slave_regif #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sclk,
   input  logic                    cs,
   input  logic                    mosi,
   output logic                    miso,
   output logic                    miso_oe,
   spi_slave_regif_if.master       reg_bus,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic [FRAME_BITS-1:0]   rx_frame
);
   import ecg_spi_pkg::*;

   localparam int CNT_W = $clog2(FRAME_BITS + 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .din(cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   // Only edges of SCLK/CS and the level of MOSI matter here.
   logic unused_sync;
   assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

   spi_state_t              state, state_nxt;
   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-2:0]   rx_shift;      // incoming bit completes the frame
   logic [DATA_W-1:0]       tx_shift;
   logic [FRAME_BITS-1:0]   rx_frame_next;
   logic [ADDR_W-1:0]       addr_q;
   logic [DATA_W-1:0]       wr_data_q;
   logic                    is_read;
   logic                    rd_req_q, rd_load_q, wr_en_q;
   logic                    miso_q, miso_oe_q;

   logic shift_in, shift_out, latch_cmd, latch_frame, end_ok, end_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A CS rise takes priority over a coincident SCLK edge, discarding that bit.
   always_comb begin
      state_nxt   = state;
      shift_in    = 1'b0;
      shift_out   = 1'b0;
      latch_cmd   = 1'b0;
      latch_frame = 1'b0;
      end_ok      = 1'b0;
      end_err     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) state_nxt = CMD;
         end
         CMD: begin
            if (cs_rise) begin
               end_err   = 1'b1;
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               shift_in = 1'b1;
               if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
                  latch_cmd = 1'b1;
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (cs_rise) begin
               end_err   = 1'b1;
               state_nxt = IDLE;
            end else if (sclk_rise) begin
               shift_in = 1'b1;
               if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                  latch_frame = 1'b1;
                  state_nxt   = HOLD;
               end
            end else if (sclk_fall) begin
               shift_out = 1'b1;
            end
         end
         HOLD: begin
            if (cs_rise) begin
               end_ok    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         rx_frame_next <= '0;
         rx_frame      <= '0;
         addr_q        <= '0;
         wr_data_q     <= '0;
         is_read       <= 1'b0;
         rd_req_q      <= 1'b0;
         rd_load_q     <= 1'b0;
         wr_en_q       <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         frame_done    <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         rd_req_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         // Bank answers 1 clk after the request; capture it one clk after that.
         rd_load_q  <= rd_req_q;
         miso_oe_q  <= (state_nxt != IDLE);

         if (state_nxt == IDLE) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else if (shift_in) begin
            bit_cnt  <= bit_cnt + 1'b1;
            rx_shift <= {rx_shift[FRAME_BITS-3:0], mosi_s};
         end

         if (latch_cmd) begin
            addr_q   <= rx_shift[ADDR_W-1:0];
            is_read  <= (mosi_s == SPI_RD);
            rd_req_q <= (mosi_s == SPI_RD);
         end

         if (latch_frame) begin
            rx_frame_next <= {rx_shift, mosi_s};
            if (!is_read) begin
               wr_en_q   <= 1'b1;
               wr_data_q <= {rx_shift[DATA_W-2:0], mosi_s};
            end
         end

         if (rd_load_q) begin
            tx_shift <= reg_bus.reg_rd_data;
         end else if (state_nxt == IDLE) begin
            tx_shift <= '0;
         end else if (shift_out) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
         end

         // MISO is only ever driven with data in DATA; write frames return zeros.
         if (state_nxt != DATA) begin
            miso_q <= 1'b0;
         end else if (shift_out) begin
            miso_q <= is_read & tx_shift[DATA_W-1];
         end

         if (end_ok) begin
            frame_done <= 1'b1;
            rx_frame   <= rx_frame_next;
         end
         if (end_err) begin
            frame_err <= 1'b1;
         end
      end
   end

   assign miso                = miso_q;
   assign miso_oe             = miso_oe_q;
   assign reg_bus.reg_addr    = addr_q;
   assign reg_bus.reg_rd_req  = rd_req_q;
   assign reg_bus.reg_wr_en   = wr_en_q;
   assign reg_bus.reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Bench for spi_slave_regif: an SPI master task drives frames, an emulated register bank
// answers reads, and a monitor checks every strobe against an expected-event queue.
module tb_spi_slave_regif;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk, cs, mosi;
   logic        miso, miso_oe;
   logic        frame_done, frame_err;
   logic [31:0] rx_frame;
   logic [23:0] rd_value;

   int n_vec = 0;
   int n_err = 0;

   localparam int EV_WR   = 0;
   localparam int EV_RD   = 1;
   localparam int EV_DONE = 2;
   localparam int EV_ERR  = 3;

   typedef struct {
      int          kind;
      logic [6:0]  addr;
      logic [31:0] data;
   } ev_t;

   ev_t exp_q[$];

   spi_slave_regif_if bus ();

   spi_slave_regif #(.SYNC_STAGES(2), .FRAME_BITS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs         (cs),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .reg_bus    (bus),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .rx_frame   (rx_frame)
   );

   always #5 clk = ~clk;

   // Register bank: data valid only in the single clk after the request.
   always @(posedge clk) begin
      bus.reg_rd_data <= bus.reg_rd_req ? rd_value : 24'h0;
   end

   task automatic push_ev(input int kind, input logic [6:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [6:0] a, input logic [31:0] d);
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected none", kind, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr != a || e.data != d) begin
            n_err++;
            $display("FAIL event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                     kind, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.reg_rd_req) check_ev(EV_RD, bus.reg_addr, 32'h0);
         if (bus.reg_wr_en)  check_ev(EV_WR, bus.reg_addr, {8'h0, bus.reg_wr_data});
         if (frame_done)     check_ev(EV_DONE, 7'h0, rx_frame);
         if (frame_err)      check_ev(EV_ERR, 7'h0, 32'h0);
      end
   end

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic check_zero(input string name);
      check_val(name, {7'h0, miso, miso_oe, bus.reg_addr, bus.reg_rd_req, bus.reg_wr_en,
                       frame_done, frame_err, bus.reg_wr_data}, 64'h0);
      check_val({name, "_rx_frame"}, {32'h0, rx_frame}, 64'h0);
   endtask

   // SPI mode-0 master: MSB first, MOSI changes while SCLK is low, MISO sampled on rise.
   // rst_at >= 0 pulses reset before that bit while the frame keeps clocking.
   task automatic spi_xfer(input logic [39:0] tx, input int nbits, input int half,
                           input int gap, input int rst_at, output logic [39:0] rx);
      rx = '0;
      @(posedge clk); #2;
      cs   = 1'b0;
      mosi = tx[nbits-1];
      repeat (4) @(posedge clk);
      #2;
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 check_zero("rst_mid");
            @(posedge clk); #2;
            rst = 1'b0;
         end
         mosi = tx[nbits-1-i];
         repeat (half) @(posedge clk);
         #2 sclk = 1'b1;
         rx = {rx[38:0], miso};
         repeat (half) @(posedge clk);
         #2 sclk = 1'b0;
      end
      repeat (half) @(posedge clk);
      #2;
      cs   = 1'b1;
      mosi = 1'b0;
      repeat (gap) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [39:0] rx;
      rst      = 1'b1;
      sclk     = 1'b0;
      cs       = 1'b1;
      mosi     = 1'b0;
      rd_value = 24'h0;
      repeat (4) @(posedge clk);
      #1 check_zero("reset_state");
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (6) @(posedge clk);

      // Write addr 0x09 data 0x345678 at 2 MHz.
      push_ev(EV_WR, 7'h09, 32'h0034_5678);
      push_ev(EV_DONE, 7'h0, 32'h1234_5678);
      spi_xfer({8'h0, 32'h1234_5678}, 32, 25, 10, -1, rx);
      check_val("wr_miso_zero", {24'h0, rx}, 64'h0);

      // Read addr 0x0F, bank returns 0xA5C3F0.
      rd_value = 24'hA5C3F0;
      push_ev(EV_RD, 7'h0F, 32'h0);
      push_ev(EV_DONE, 7'h0, 32'h1F00_0000);
      spi_xfer({8'h0, 32'h1F00_0000}, 32, 25, 10, -1, rx);
      check_val("rd_miso_word", {32'h0, rx[31:0]}, {32'h0, 32'h00A5_C3F0});

      // Abort after 20 bits of a write to addr 0x01.
      push_ev(EV_ERR, 7'h0, 32'h0);
      spi_xfer({8'h0, 32'h02AB_CDEF >> 12}, 20, 25, 10, -1, rx);
      check_val("abort_rx_frame_kept", {32'h0, rx_frame}, {32'h0, 32'h1F00_0000});

      // Overrun: 40 clocks, write addr 0x02 data 0x000001, extra bits ignored.
      push_ev(EV_WR, 7'h02, 32'h0000_0001);
      push_ev(EV_DONE, 7'h0, 32'h0400_0001);
      spi_xfer({32'h0400_0001, 8'hFF}, 40, 25, 10, -1, rx);
      check_val("overrun_miso_zero", {24'h0, rx}, 64'h0);

      // Reset at bit 12 of a write: no strobes, no frame_err, no frame_done.
      spi_xfer({8'h0, 32'h0ADE_AD00}, 32, 25, 10, 12, rx);
      push_ev(EV_WR, 7'h03, 32'h00FF_FFFF);
      push_ev(EV_DONE, 7'h0, 32'h06FF_FFFF);
      spi_xfer({8'h0, 32'h06FF_FFFF}, 32, 25, 10, -1, rx);

      // Back-to-back read then write at the minimum half-period, CS high 4 clk.
      rd_value = 24'h123ABC;
      push_ev(EV_RD, 7'h05, 32'h0);
      push_ev(EV_DONE, 7'h0, 32'h0B00_0000);
      spi_xfer({8'h0, 32'h0B00_0000}, 32, 8, 4, -1, rx);
      check_val("b2b_rd_miso_word", {32'h0, rx[31:0]}, {32'h0, 32'h0012_3ABC});
      push_ev(EV_WR, 7'h7F, 32'h0000_FF00);
      push_ev(EV_DONE, 7'h0, 32'hFE00_FF00);
      spi_xfer({8'h0, 32'hFE00_FF00}, 32, 8, 20, -1, rx);

      repeat (20) @(posedge clk);
      #1 check_val("missing_events", 64'(exp_q.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
